// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin merge of valid/ready streams with optional burst lock and a registered output.
module stream_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int BURST = 1,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          clear
);
  localparam int BW = $clog2(BURST + 1);
  logic [ID_WIDTH-1:0] ptr, owner, rr_sel, sel, idx, next_ptr;
  logic [BW-1:0] beats, next_beats;
  logic owner_valid, rr_found, burst_hit, load_en, grant;
  logic [DATA_WIDTH-1:0] sel_data;
  always_comb begin
    rr_sel = '0;
    rr_found = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (in_valid[idx]) begin
        rr_found = 1'b1;
        rr_sel = idx;
      end
    end
  end
  assign load_en = !out_valid || out_ready;
  assign burst_hit = owner_valid && in_valid[owner] && (beats < BW'(BURST));
  assign grant = rstn && load_en && !clear && (burst_hit || rr_found);
  assign sel = burst_hit ? owner : rr_sel;
  assign in_ready = grant ? (NUM_REQ'(1) << sel) : '0;
  assign sel_data = in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign next_beats = (owner_valid && owner == sel) ? beats + 1'b1 : BW'(1);
  assign next_ptr = (sel == ID_WIDTH'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= '0;
      ptr <= '0;
      owner_valid <= 1'b0;
      owner <= '0;
      beats <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      ptr <= '0;
      owner_valid <= 1'b0;
      beats <= '0;
    end else if (grant) begin
      out_data <= sel_data;
      out_id <= sel;
      out_valid <= 1'b1;
      ptr <= next_ptr;
      owner <= sel;
      beats <= next_beats;
      owner_valid <= next_beats != BW'(BURST);
    end else if (load_en) begin
      // register drained (or empty); an idle owner loses its lock
      out_valid <= 1'b0;
      if (owner_valid && !in_valid[owner]) owner_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed scoreboard bench for two arbiter instances (BURST=1 and BURST=2).
module tb_stream_rr_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] iv1 = '0, iv2 = '0, ir1, ir2;
  logic [7:0] d1[4], d2[4], ed1[4], ed2[4];
  logic [31:0] in_data1, in_data2;
  logic [7:0] od1, od2;
  logic [1:0] oid1, oid2;
  logic ov1, ov2;
  logic ordy1 = 1'b1, ordy2 = 1'b1, clr1 = 1'b0, clr2 = 1'b0;
  logic [9:0] q1[$], q2[$];
  int total = 0, bad = 0;
  assign in_data1 = {d1[3], d1[2], d1[1], d1[0]};
  assign in_data2 = {d2[3], d2[2], d2[1], d2[0]};

  stream_rr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BURST(1)) u1 (
    .clk(clk), .rstn(rstn), .in_data(in_data1), .in_valid(iv1), .in_ready(ir1),
    .out_data(od1), .out_id(oid1), .out_valid(ov1), .out_ready(ordy1), .clear(clr1));
  stream_rr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BURST(2)) u2 (
    .clk(clk), .rstn(rstn), .in_data(in_data2), .in_valid(iv2), .in_ready(ir2),
    .out_data(od2), .out_id(oid2), .out_valid(ov2), .out_ready(ordy2), .clear(clr2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input int id);
    q1.push_back({2'(id), ed1[id]});
    ed1[id]++;
  endtask

  task automatic push2(input int id);
    q2.push_back({2'(id), ed2[id]});
    ed2[id]++;
  endtask

  // sample handshakes mid-cycle, then advance producers just after the edge
  task automatic tick();
    logic [3:0] f1, f2;
    logic [31:0] e;
    @(negedge clk);
    f1 = iv1 & ir1;
    f2 = iv2 & ir2;
    if (ov1 && ordy1 && !clr1) begin
      e = (q1.size() > 0) ? {22'd1, q1.pop_front()} : 32'd0;
      chk("beat1", {22'd1, oid1, od1}, e);
    end
    if (ov2 && ordy2 && !clr2) begin
      e = (q2.size() > 0) ? {22'd1, q2.pop_front()} : 32'd0;
      chk("beat2", {22'd1, oid2, od2}, e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (f1[i]) d1[i]++;
      if (f2[i]) d2[i]++;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 6 && (q1.size() > 0 || q2.size() > 0); n++) tick();
    chk("drain_empty", 32'(q1.size() + q2.size()), 32'd0);
    chk("drain_idle", 32'({ov1, ov2}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      d1[i] = 8'(16 * i);
      ed1[i] = 8'(16 * i);
      d2[i] = 8'(16 * i);
      ed2[i] = 8'(16 * i);
    end
    iv1 = 4'hF;
    iv2 = 4'hF;
    #1 rstn = 1'b0;
    repeat (10) begin
      tick();
      chk("rst_ir1", 32'(ir1), 32'd0);
      chk("rst_ir2", 32'(ir2), 32'd0);
      chk("rst_ov", 32'({ov1, ov2}), 32'd0);
    end
    chk("rst_data", 32'({oid1, od1, oid2, od2}), 32'd0);
    iv2 = 4'h0;
    rstn = 1'b1;
    // pure round-robin, one beat per cycle
    for (int i = 0; i < 8; i++) push1(i % 4);
    repeat (8) tick();
    iv1 = 4'h0;
    tick();
    chk("rr_rate", 32'(q1.size()), 32'd0);
    chk("rr_idle", 32'(ov1), 32'd0);
    // sparse requesters and pointer wrap
    push1(1);
    iv1 = 4'b0010;
    tick();
    push1(3);
    push1(1);
    push1(3);
    iv1 = 4'b1010;
    repeat (3) tick();
    push1(0);
    iv1 = 4'hF;
    tick();
    iv1 = 4'h0;
    drain();
    // back-pressure holds the beat
    d1[2] = 8'hA5;
    ed1[2] = 8'hA5;
    push1(2);
    iv1 = 4'b0100;
    tick();
    ordy1 = 1'b0;
    iv1 = 4'hF;
    repeat (5) begin
      tick();
      chk("bp_hold", 32'({oid1, od1}), 32'({2'd2, 8'hA5}));
      chk("bp_ir", 32'(ir1), 32'd0);
      chk("bp_ov", 32'(ov1), 32'd1);
    end
    iv1 = 4'h0;
    ordy1 = 1'b1;
    drain();
    // clear discards the held beat and resets the pointer
    iv1 = 4'b0010;
    tick();
    ed1[1]++;
    clr1 = 1'b1;
    iv1 = 4'hF;
    tick();
    chk("clr_ir", 32'(ir1), 32'd0);
    clr1 = 1'b0;
    chk("clr_ov", 32'(ov1), 32'd0);
    push1(0);
    tick();
    iv1 = 4'h0;
    drain();
    // burst lock of two beats
    for (int i = 0; i < 8; i++) push2(i / 2);
    iv2 = 4'hF;
    repeat (8) tick();
    iv2 = 4'h0;
    tick();
    chk("burst_rate", 32'(q2.size()), 32'd0);
    push2(0);
    iv2 = 4'hF;
    tick();
    push2(1);
    push2(1);
    iv2 = 4'b1110;
    repeat (2) tick();
    iv2 = 4'h0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
